// File: rtl/semaforo_multi.sv
// Multi-approach traffic light with pedestrian phase and rotating green ownership.
// Define SEMAFORO_PED_REQ_EN to serve the pedestrian phase only on request; otherwise it follows every rotation.
module semaforo_multi #(
    parameter int N_DIR       = 4,
    parameter int T_GREEN     = 10,
    parameter int T_BLINK     = 5,
    parameter int T_YELLOW    = 5,
    parameter int T_CLEAR     = 2,
    parameter int T_PED       = 10,
    parameter int T_PED_BLINK = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ped_req,
    output logic [3*N_DIR-1:0] luz,
    output logic [1:0]         peatonal,
    output logic [2:0]         dir_act,
    output logic               ped_wait
);

    typedef enum logic [2:0] {
        GREEN     = 3'd0,
        BLINK     = 3'd1,
        YELLOW    = 3'd2,
        CLEAR     = 3'd3,
        PED       = 3'd4,
        PED_BLINK = 3'd5
    } state_t;

    localparam logic [2:0] V      = 3'b011;
    localparam logic [2:0] VB     = 3'b100;
    localparam logic [2:0] AMA    = 3'b101;
    localparam logic [2:0] ROJ    = 3'b110;
    localparam logic [1:0] VER_P  = 2'b00;
    localparam logic [1:0] VER_PB = 2'b01;
    localparam logic [1:0] ROJ_P  = 2'b10;

    localparam logic [CNT_W-1:0] LAST_GREEN     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LAST_BLINK     = CNT_W'(T_BLINK - 1);
    localparam logic [CNT_W-1:0] LAST_YELLOW    = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_CLEAR     = CNT_W'(T_CLEAR - 1);
    localparam logic [CNT_W-1:0] LAST_PED       = CNT_W'(T_PED - 1);
    localparam logic [CNT_W-1:0] LAST_PED_BLINK = CNT_W'(T_PED_BLINK - 1);
    localparam logic [2:0]       DIR_LAST       = 3'(N_DIR - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dir_q, dir_d;
    logic             pend_q, pend_d;

    logic       phase_end;
    logic       ped_go;
    logic [2:0] dir_nxt;
    logic [2:0] lamp;
    logic       approach_on;

`ifdef SEMAFORO_PED_REQ_EN
    assign ped_go = pend_q;
`else
    assign ped_go = (dir_q == DIR_LAST);
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        dir_d     = dir_q;
        phase_end = 1'b0;
        dir_nxt   = (dir_q == DIR_LAST) ? '0 : dir_q + 3'd1;
`ifdef SEMAFORO_PED_REQ_EN
        pend_d    = pend_q | ped_req;
`else
        pend_d    = 1'b0;
`endif
        case (state_q)
            GREEN:     phase_end = (cnt_q == LAST_GREEN);
            BLINK:     phase_end = (cnt_q == LAST_BLINK);
            YELLOW:    phase_end = (cnt_q == LAST_YELLOW);
            CLEAR:     phase_end = (cnt_q == LAST_CLEAR);
            PED:       phase_end = (cnt_q == LAST_PED);
            PED_BLINK: phase_end = (cnt_q == LAST_PED_BLINK);
            default:   phase_end = 1'b1;
        endcase
        if (phase_end) begin
            cnt_d = '0;
            case (state_q)
                GREEN:  state_d = BLINK;
                BLINK:  state_d = YELLOW;
                YELLOW: state_d = CLEAR;
                CLEAR: begin
                    if (ped_go) begin
                        state_d = PED;
                        // A press seen on the entry cycle is served by this same phase.
                        pend_d  = 1'b0;
                    end else begin
                        state_d = GREEN;
                        dir_d   = dir_nxt;
                    end
                end
                PED:       state_d = PED_BLINK;
                PED_BLINK: begin
                    state_d = GREEN;
                    dir_d   = dir_nxt;
                end
                default: begin
                    state_d = CLEAR;
                    dir_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GREEN;
            cnt_q   <= '0;
            dir_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        lamp        = ROJ;
        approach_on = 1'b0;
        peatonal    = ROJ_P;
        case (state_q)
            GREEN:     begin lamp = V;   approach_on = 1'b1; end
            BLINK:     begin lamp = VB;  approach_on = 1'b1; end
            YELLOW:    begin lamp = AMA; approach_on = 1'b1; end
            CLEAR:     begin lamp = ROJ; approach_on = 1'b1; end
            PED:       peatonal = VER_P;
            PED_BLINK: peatonal = VER_PB;
            default:   peatonal = ROJ_P;
        endcase
        luz = {N_DIR{ROJ}};
        for (int unsigned k = 0; k < N_DIR; k++) begin
            if (approach_on && (3'(k) == dir_q)) begin
                luz[3*k +: 3] = lamp;
            end
        end
    end

    assign dir_act  = dir_q;
    assign ped_wait = pend_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed bench for semaforo_multi: hand-written phase timelines compared cycle by cycle.
module tb_semaforo_multi;

    localparam int N_DIR   = 3;
    localparam int APP_LEN = 9;
    localparam int PED_LEN = 5;
    localparam int PED_SEG = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ped_req = 1'b0;
    logic [8:0] luz;
    logic [1:0] peatonal;
    logic [2:0] dir_act;
    logic       ped_wait;

    int checks = 0;
    int errors = 0;
    int seg_q[$];

    semaforo_multi #(
        .N_DIR(3), .T_GREEN(4), .T_BLINK(2), .T_YELLOW(2), .T_CLEAR(1),
        .T_PED(3), .T_PED_BLINK(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .ped_req(ped_req),
        .luz(luz), .peatonal(peatonal), .dir_act(dir_act), .ped_wait(ped_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ped_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Walk the segment list (approach k = 9 cycles, PED_SEG = 5 cycles) from cycle 0 after reset release.
    task automatic run_sched(input string name, input int ncyc, input int p1, input int p2,
                             input bit hold, input bit rnd,
                             input int w1l, input int w1h, input int w2l, input int w2h);
        int si = 0;
        int off = 0;
        int seg;
        int nonroj;
        logic [8:0] exp_luz;
        logic [1:0] exp_pea;
        logic [2:0] code;
        logic       exp_wait;
        for (int t = 0; t < ncyc; t++) begin
            if (si >= seg_q.size()) begin
                errors++;
                checks++;
                $display("FAIL %s schedule_overrun t=%0d got si=%0d want <%0d", name, t, si, seg_q.size());
                break;
            end
            seg = seg_q[si];
            exp_luz = {3{3'b110}};
            if (seg == PED_SEG) begin
                exp_pea = (off < 3) ? 2'b00 : 2'b01;
            end else begin
                exp_pea = 2'b10;
                if (off < 4)      code = 3'b011;
                else if (off < 6) code = 3'b100;
                else if (off < 8) code = 3'b101;
                else              code = 3'b110;
                exp_luz[3*seg +: 3] = code;
            end
            if (hold) exp_wait = !(t == 0 || (seg == PED_SEG && off == 0));
            else      exp_wait = (t >= w1l && t <= w1h) || (t >= w2l && t <= w2h);

            checks++;
            if (luz !== exp_luz) begin
                errors++;
                $display("FAIL %s luz t=%0d got %b want %b", name, t, luz, exp_luz);
            end
            checks++;
            if (peatonal !== exp_pea) begin
                errors++;
                $display("FAIL %s peatonal t=%0d got %b want %b", name, t, peatonal, exp_pea);
            end
            if (seg != PED_SEG) begin
                checks++;
                if (dir_act !== 3'(seg)) begin
                    errors++;
                    $display("FAIL %s dir_act t=%0d got %0d want %0d", name, t, dir_act, seg);
                end
            end
            checks++;
            if (ped_wait !== exp_wait) begin
                errors++;
                $display("FAIL %s ped_wait t=%0d got %b want %b", name, t, ped_wait, exp_wait);
            end
            nonroj = 0;
            for (int k = 0; k < N_DIR; k++) if (luz[3*k +: 3] !== 3'b110) nonroj++;
            checks++;
            if (nonroj > 1) begin
                errors++;
                $display("FAIL %s exclusive t=%0d got %0d non-red want <=1", name, t, nonroj);
            end

            if (hold)     ped_req = 1'b1;
            else if (rnd) ped_req = 1'($urandom_range(0, 1));
            else          ped_req = (t == p1 || t == p2);

            off++;
            if (off == ((seg == PED_SEG) ? PED_LEN : APP_LEN)) begin
                off = 0;
                si++;
            end
            if (t < ncyc - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (luz !== 9'b110_110_011) begin errors++; $display("FAIL reset_luz got %b want %b", luz, 9'b110_110_011); end
        checks++;
        if (peatonal !== 2'b10) begin errors++; $display("FAIL reset_peatonal got %b want 10", peatonal); end
        checks++;
        if (dir_act !== 3'd0) begin errors++; $display("FAIL reset_dir_act got %0d want 0", dir_act); end
        checks++;
        if (ped_wait !== 1'b0) begin errors++; $display("FAIL reset_ped_wait got %b want 0", ped_wait); end
        rst = 1'b0;
        ped_req = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (luz !== 9'b110_110_100) begin errors++; $display("FAIL pre_async_luz got %b want %b", luz, 9'b110_110_100); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (luz !== 9'b110_110_011) begin errors++; $display("FAIL async_reset_luz got %b want %b", luz, 9'b110_110_011); end
        checks++;
        if (ped_wait !== 1'b0) begin errors++; $display("FAIL async_reset_ped_wait got %b want 0", ped_wait); end
        ped_req = 1'b0;
    endtask

    task automatic test_reset_in_ped(input int ncyc, input int p1, input int p2,
                                     input int w1l, input int w1h, input int w2l, input int w2h,
                                     input bit rnd);
        do_reset();
        run_sched("pre_ped_reset", ncyc, p1, p2, 1'b0, rnd, w1l, w1h, w2l, w2h);
        checks++;
        if (peatonal !== 2'b01) begin errors++; $display("FAIL ped_blink_reached got %b want 01", peatonal); end
        #2;
        rst = 1'b1;
        ped_req = 1'b0;
        #1;
        checks++;
        if (luz !== 9'b110_110_011) begin errors++; $display("FAIL ped_reset_luz got %b want %b", luz, 9'b110_110_011); end
        checks++;
        if (peatonal !== 2'b10) begin errors++; $display("FAIL ped_reset_peatonal got %b want 10", peatonal); end
        checks++;
        if (dir_act !== 3'd0) begin errors++; $display("FAIL ped_reset_dir_act got %0d want 0", dir_act); end
        checks++;
        if (ped_wait !== 1'b0) begin errors++; $display("FAIL ped_reset_ped_wait got %b want 0", ped_wait); end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef SEMAFORO_PED_REQ_EN
    task automatic test_no_req();
        do_reset();
        seg_q = {0, 1, 2, 0, 1, 2};
        run_sched("no_req", 54, -1, -1, 1'b0, 1'b0, -1, -2, -1, -2);
    endtask

    task automatic test_single_req();
        do_reset();
        seg_q = {0, 1, PED_SEG, 2, 0};
        run_sched("single_req", 40, 10, -1, 1'b0, 1'b0, 11, 17, -1, -2);
    endtask

    task automatic test_absorb();
        do_reset();
        seg_q = {0, 1, PED_SEG, 2, 0, 1};
        run_sched("absorb", 45, 10, 17, 1'b0, 1'b0, 11, 17, -1, -2);
    endtask

    task automatic test_req_in_ped();
        do_reset();
        seg_q = {0, 1, PED_SEG, 2, PED_SEG, 0, 1};
        run_sched("req_in_ped", 50, 10, 19, 1'b0, 1'b0, 11, 17, 20, 31);
    endtask

    task automatic test_hold();
        do_reset();
        seg_q = {0, PED_SEG, 1, PED_SEG, 2, PED_SEG, 0, PED_SEG};
        run_sched("hold", 50, -1, -1, 1'b1, 1'b0, -1, -2, -1, -2);
        ped_req = 1'b0;
    endtask
`else
    task automatic test_rotation();
        do_reset();
        seg_q.delete();
        for (int r = 0; r < 4; r++) begin
            seg_q.push_back(0); seg_q.push_back(1); seg_q.push_back(2); seg_q.push_back(PED_SEG);
        end
        run_sched("rotation", 100, -1, -1, 1'b0, 1'b1, -1, -2, -1, -2);
    endtask
`endif

    initial begin
        test_reset();
`ifdef SEMAFORO_PED_REQ_EN
        test_no_req();
        test_single_req();
        test_absorb();
        test_req_in_ped();
        test_hold();
        seg_q = {0, 1, PED_SEG};
        test_reset_in_ped(22, 10, 19, 11, 17, 20, 21, 1'b0);
        seg_q = {0, 1, 2, 0};
        run_sched("after_ped_reset", 30, -1, -1, 1'b0, 1'b0, -1, -2, -1, -2);
`else
        test_rotation();
        seg_q = {0, 1, 2, PED_SEG, 0};
        test_reset_in_ped(31, -1, -1, -1, -2, -1, -2, 1'b1);
        seg_q = {0, 1, 2, PED_SEG, 0, 1};
        run_sched("after_ped_reset", 40, -1, -1, 1'b0, 1'b1, -1, -2, -1, -2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/semaforo_multi.md
SEMAFORO_MULTI -- requirements
Module: semaforo_multi

Interface
REQ-001 SHALL have parameter N_DIR, default 4: number of vehicle approaches served in rotation; legal range 2..8.
REQ-002 SHALL have parameters T_GREEN=10, T_BLINK=5, T_YELLOW=5, T_CLEAR=2, T_PED=10, T_PED_BLINK=5: phase durations in clk cycles; each at least 1.
REQ-003 SHALL have parameter CNT_W, default 16: phase counter width; must hold the largest T_* value.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named clk and rst as elsewhere in the codebase.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ped_req  input  1  pedestrian button, level-sampled each cycle, no debounce inside.
REQ-008 luz  output  3*N_DIR  per-approach lamp code, approach k at bits [3k+2:3k].
REQ-009 peatonal  output  2  pedestrian lamp code.
REQ-010 dir_act  output  3  index of the approach currently owning green/blink/yellow/clear.
REQ-011 ped_wait  output  1  pedestrian request pending.

Function
REQ-012 Lamp codes SHALL be: V=011, Vb (green blink)=100, AMA=101, ROJ=110; pedestrian VER_P=00, VER_Pb=01, ROJ_P=10.
REQ-013 FSM states SHALL be GREEN, BLINK, YELLOW, CLEAR, PED, PED_BLINK; each state lasts exactly its T_* cycles, counted 0..T-1, then transitions.
REQ-014 Transitions SHALL be GREEN->BLINK->YELLOW->CLEAR; CLEAR->PED if the pending flag is set at the last CLEAR cycle, otherwise CLEAR->GREEN with dir_act+1; PED->PED_BLINK->GREEN with dir_act+1.
REQ-015 dir_act SHALL wrap from N_DIR-1 to 0.
REQ-016 luz for approach dir_act SHALL be V, Vb, AMA or ROJ in GREEN, BLINK, YELLOW or CLEAR respectively; all other approaches SHALL be ROJ; all approaches SHALL be ROJ in PED and PED_BLINK.
REQ-017 peatonal SHALL be VER_P in PED, VER_Pb in PED_BLINK and ROJ_P otherwise.
REQ-018 Outputs SHALL be Moore-decoded from registered state, counter and dir_act, with no added latency; state changes SHALL be visible on the clk edge ending the previous phase.
REQ-019 The pending flag SHALL set on any cycle with ped_req=1 and clear on the cycle PED is entered; if ped_req=1 is also seen on that entry cycle, the request is absorbed and the flag stays clear.
REQ-020 A ped_req seen during PED or PED_BLINK, after the entry cycle, SHALL set the flag for the next opportunity.
REQ-021 No two approaches SHALL be non-ROJ in the same cycle.
REQ-022 Illegal state encodings SHALL recover to CLEAR with dir_act=0 and the counter cleared.

Reset
REQ-023 While rst=1: state=GREEN, dir_act=0, counter=0, pending flag=0.
REQ-024 Resulting outputs: luz approach 0=V, others=ROJ, peatonal=ROJ_P, ped_wait=0.
REQ-025 Reset mid-phase SHALL abort the phase immediately, including PED; a pending request SHALL be lost.

Configuration
REQ-026 With macro SEMAFORO_PED_REQ_EN defined, the pedestrian phase occurs only on request per REQ-014/019.
REQ-027 Without SEMAFORO_PED_REQ_EN, ped_req is ignored, ped_wait is tied to 0, and PED is entered after the CLEAR of approach N_DIR-1 every rotation.

Verification (N_DIR=3, T_GREEN=4, T_BLINK=2, T_YELLOW=2, T_CLEAR=1, T_PED=3, T_PED_BLINK=2, SEMAFORO_PED_REQ_EN defined unless noted)
REQ-028 Release rst with no ped_req -> approach 0 is V for 4 cycles, Vb for 2, AMA for 2, ROJ for 1; then approach 1 is V. Rotation repeats every 27 cycles, peatonal stays ROJ_P.
REQ-029 Pulse ped_req for 1 cycle during approach 1 GREEN -> ped_wait=1 until PED entry; after approach 1 CLEAR, peatonal is VER_P for 3 cycles and VER_Pb for 2; next phase is approach 2 GREEN.
REQ-030 Hold ped_req=1 continuously -> a PED phase follows every approach's CLEAR. The flag re-sets during PED per REQ-020; no cycle ever shows two approaches non-ROJ.
REQ-031 ped_req=1 only on the PED entry cycle -> ped_wait=0 after entry; no second PED phase follows.
REQ-032 Assert rst for 1 cycle during PED_BLINK -> outputs return immediately to the REQ-024 values and ped_wait=0.
REQ-033 Build without SEMAFORO_PED_REQ_EN and toggle ped_req randomly -> PED occurs only after approach 2 CLEAR, once every 32 cycles; ped_wait is 0 throughout.
